// File: rtl/soc_ctrl_pkg.sv
// Shared types and constants for the SoC control register file.
package soc_ctrl_pkg;

  // AXI4-Lite response codes used by this slave.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  // Register 0 carries the end-of-run code written by software.
  localparam int unsigned EXIT_REG  = 0;
  localparam logic [7:0]  EXIT_CODE = 8'hFF;

  // The cycle counter sits in the top register of the file.
  localparam int unsigned NUM_REGS_DEFAULT = 8;
  localparam int unsigned CYCLE_REG        = NUM_REGS_DEFAULT - 1;

  // Top register index for a register file of any size.
  function automatic int unsigned cycle_reg_of(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage : soc_ctrl_pkg

// File: rtl/soc_cycle_counter.sv
// 64-bit free-running cycle counter; clears on rst and wraps at 2^64.
module soc_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] count_o
);

  logic [63:0] r_count;

  // Count every cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 64'd1;
    end
  end

  assign count_o = r_count;

endmodule : soc_cycle_counter

// File: rtl/soc_ctrl_regs.sv
// AXI4-Lite register file driving the SoC control vector.
// Write and read channels each run an independent two-state FSM.
// Optional feature: SOC_CTRL_REGS_CYCLE_COUNTER_EN turns the top register
// into a read-only free-running cycle counter.
module soc_ctrl_regs
  import soc_ctrl_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumRegs      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [AxiAddrWidth-1:0]               axil_awaddr_i,
  input  logic                                  axil_awvalid_i,
  output logic                                  axil_awready_o,
  input  logic [AxiDataWidth-1:0]               axil_wdata_i,
  input  logic [AxiDataWidth/8-1:0]             axil_wstrb_i,
  input  logic                                  axil_wvalid_i,
  output logic                                  axil_wready_o,
  output logic [1:0]                            axil_bresp_o,
  output logic                                  axil_bvalid_o,
  input  logic                                  axil_bready_i,
  input  logic [AxiAddrWidth-1:0]               axil_araddr_i,
  input  logic                                  axil_arvalid_i,
  output logic                                  axil_arready_o,
  output logic [AxiDataWidth-1:0]               axil_rdata_o,
  output logic [1:0]                            axil_rresp_o,
  output logic                                  axil_rvalid_o,
  input  logic                                  axil_rready_i,
  output logic [NumRegs-1:0][AxiDataWidth-1:0]  reg_q_o,
  output logic [NumRegs-1:0]                    reg_wr_o
);

  localparam int unsigned StrbW    = AxiDataWidth / 8;
  localparam int unsigned ByteOff  = $clog2(StrbW);
  localparam int unsigned IdxW     = $clog2(NumRegs);
  localparam int unsigned IdxTop   = ByteOff + IdxW;
  localparam int unsigned CycleIdx = cycle_reg_of(NumRegs);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t r_wstate, w_wstate_next;
  r_state_t r_rstate, w_rstate_next;

  logic [NumRegs-1:0][AxiDataWidth-1:0] r_regs;
  logic [NumRegs-1:0][AxiDataWidth-1:0] w_reg_view;
  logic [NumRegs-1:0]                   r_reg_wr;
  axil_resp_t                           r_bresp;
  axil_resp_t                           r_rresp;
  logic [AxiDataWidth-1:0]              r_rdata;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [IdxW-1:0] w_wr_idx;
  logic [IdxW-1:0] w_rd_idx;
  logic            w_wr_oor;
  logic            w_rd_oor;
  logic            w_wr_err;
  logic            w_unused_addr_bits;

  // Address decode: byte offset ignored, any bit above the index is out of range.
  assign w_wr_idx = axil_awaddr_i[ByteOff +: IdxW];
  assign w_rd_idx = axil_araddr_i[ByteOff +: IdxW];
  assign w_wr_oor = |axil_awaddr_i[AxiAddrWidth-1:IdxTop];
  assign w_rd_oor = |axil_araddr_i[AxiAddrWidth-1:IdxTop];
  assign w_unused_addr_bits = ^{axil_awaddr_i[ByteOff-1:0], axil_araddr_i[ByteOff-1:0]};

`ifdef SOC_CTRL_REGS_CYCLE_COUNTER_EN
  logic [63:0] w_count;

  soc_cycle_counter u_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .count_o (w_count)
  );

  // The counter register is read-only: writes to it are rejected.
  assign w_wr_err = w_wr_oor || (w_wr_idx == IdxW'(CycleIdx));

  // Present the stored registers, with the counter overlaid on the top slot.
  always_comb begin
    w_reg_view           = r_regs;
    w_reg_view[CycleIdx] = AxiDataWidth'(w_count);
  end
`else
  assign w_wr_err = w_wr_oor;

  // Present the stored registers unchanged.
  always_comb begin
    w_reg_view = r_regs;
  end
`endif

  // FSM state registers for both channels.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  // Write FSM: accept AW and W only together, then hold B until bready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_wstate_next  = r_wstate;
    w_wr_acc       = 1'b0;
    axil_bvalid_o  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_wr_acc = axil_awvalid_i && axil_wvalid_i;
        if (w_wr_acc) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        axil_bvalid_o = 1'b1;
        if (axil_bready_i) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  assign axil_awready_o = w_wr_acc;
  assign axil_wready_o  = w_wr_acc;

  // Read FSM: accept AR in idle, then hold R stable until rready.
  always_comb begin
    w_rstate_next  = r_rstate;
    w_rd_acc       = 1'b0;
    axil_arready_o = 1'b0;
    axil_rvalid_o  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        axil_arready_o = 1'b1;
        w_rd_acc       = axil_arvalid_i;
        if (w_rd_acc) w_rstate_next = R_RESP;
      end
      R_RESP: begin
        axil_rvalid_o = 1'b1;
        if (axil_rready_i) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Register storage: byte-strobed writes and a one-cycle write pulse.
  always_ff @(posedge clk) begin
    // NOTE: the register file is a handful of flops that must read 0 after
    // reset, so the whole array is reset (this is not a RAM).
    if (rst) begin
      r_regs   <= '0;
      r_reg_wr <= '0;
    end else begin
      r_reg_wr <= '0;
      if (w_wr_acc && !w_wr_err) begin
        r_reg_wr[w_wr_idx] <= 1'b1;
        for (int b = 0; b < int'(StrbW); b++) begin
          if (axil_wstrb_i[b]) r_regs[w_wr_idx][8*b +: 8] <= axil_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response capture: B status and R data latched at accept (pre-write view).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bresp <= OKAY;
      r_rresp <= OKAY;
      r_rdata <= '0;
    end else begin
      if (w_wr_acc) r_bresp <= w_wr_err ? SLVERR : OKAY;
      if (w_rd_acc) begin
        r_rresp <= w_rd_oor ? SLVERR : OKAY;
        r_rdata <= w_rd_oor ? '0 : w_reg_view[w_rd_idx];
      end
    end
  end

  assign axil_bresp_o = r_bresp;
  assign axil_rresp_o = r_rresp;
  assign axil_rdata_o = r_rdata;
  assign reg_q_o      = w_reg_view;
  assign reg_wr_o     = r_reg_wr;

endmodule : soc_ctrl_regs

// File: tb/tb_soc_ctrl_regs.sv
// Self-checking bench for soc_ctrl_regs: table-driven transactions plus
// hand-written cycle-level sequences for handshake and reset corner cases.
module tb_soc_ctrl_regs;
  import soc_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      awaddr, araddr;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic [63:0]      wdata;
  logic [7:0]       wstrb;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [63:0]      rdata;
  logic [7:0][63:0] reg_q;
  logic [7:0]       reg_wr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_ctrl_regs dut (
    .clk            (clk),
    .rst            (rst),
    .axil_awaddr_i  (awaddr),
    .axil_awvalid_i (awvalid),
    .axil_awready_o (awready),
    .axil_wdata_i   (wdata),
    .axil_wstrb_i   (wstrb),
    .axil_wvalid_i  (wvalid),
    .axil_wready_o  (wready),
    .axil_bresp_o   (bresp),
    .axil_bvalid_o  (bvalid),
    .axil_bready_i  (bready),
    .axil_araddr_i  (araddr),
    .axil_arvalid_i (arvalid),
    .axil_arready_o (arready),
    .axil_rdata_o   (rdata),
    .axil_rresp_o   (rresp),
    .axil_rvalid_o  (rvalid),
    .axil_rready_i  (rready),
    .reg_q_o        (reg_q),
    .reg_wr_o       (reg_wr)
  );

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_wr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Full write; returns bresp and the reg_wr_o pulse seen in the cycle after accept.
  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp,
                           output logic [7:0] pulse);
    int n = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout("write_accept");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_t1", 64'(bvalid), 64'd1);
    resp  = bresp;
    pulse = reg_wr;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Full read; returns rdata and rresp latched at accept.
  task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                          output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    #1;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout("read_accept");
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_t1", 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    logic [63:0] d, v1, v2;
    logic [1:0]  r;
    logic [7:0]  p;

    vecs[0]  = '{"w_reg2_full",  1'b0, 32'h10,   64'h1122334455667788, 8'hFF, 64'h0, OKAY,   8'h04};
    vecs[1]  = '{"w_reg2_byte1", 1'b0, 32'h10,   64'h000000000000AA00, 8'h02, 64'h0, OKAY,   8'h04};
    vecs[2]  = '{"r_reg2",       1'b1, 32'h10,   64'h0, 8'h00, 64'h112233445566AA88, OKAY,   8'h00};
    vecs[3]  = '{"w_oor_1000",   1'b0, 32'h1000, 64'hDEAD, 8'hFF, 64'h0, SLVERR, 8'h00};
    vecs[4]  = '{"r_oor_1000",   1'b1, 32'h1000, 64'h0, 8'h00, 64'h0, SLVERR, 8'h00};
    vecs[5]  = '{"r_reg0_exit",  1'b1, 32'h0,    64'h0, 8'h00, 64'hFF, OKAY, 8'h00};
    vecs[6]  = '{"w_reg3_nostb", 1'b0, 32'h18,   64'hCAFE, 8'h00, 64'h0, OKAY, 8'h08};
    vecs[7]  = '{"r_reg3_zero",  1'b1, 32'h18,   64'h0, 8'h00, 64'h0, OKAY, 8'h00};
    vecs[8]  = '{"w_reg3_lowbit",1'b0, 32'h1C,   64'h1234, 8'hFF, 64'h0, OKAY, 8'h08};
    vecs[9]  = '{"r_reg3",       1'b1, 32'h18,   64'h0, 8'h00, 64'h1234, OKAY, 8'h00};
    vecs[10] = '{"w_oor_40",     1'b0, 32'h40,   64'h99, 8'hFF, 64'h0, SLVERR, 8'h00};
    vecs[11] = '{"r_oor_40",     1'b1, 32'h40,   64'h0, 8'h00, 64'h0, SLVERR, 8'h00};
    vecs[12] = '{"r_reg1_zero",  1'b1, 32'h08,   64'h0, 8'h00, 64'h0, OKAY, 8'h00};

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rdata",   rdata,        64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_reg_wr",  64'(reg_wr),  64'd0);
    check("rst_reg0",    reg_q[0],     64'd0);
    check("rst_reg6",    reg_q[6],     64'd0);

    // Exit write to register 0, checked cycle by cycle.
    @(negedge clk);
    awaddr = 32'h0; wdata = 64'(EXIT_CODE); wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    check("exit_awready", 64'(awready), 64'd1);
    check("exit_wready",  64'(wready),  64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("exit_reg0",   reg_q[EXIT_REG], 64'hFF);
    check("exit_wr_t1",  64'(reg_wr),     64'h01);
    check("exit_bvalid", 64'(bvalid),     64'd1);
    check("exit_bresp",  64'(bresp),      64'(OKAY));
    @(negedge clk);
    bready = 1'b0;
    check("exit_wr_t2",  64'(reg_wr), 64'd0);
    check("exit_bdone",  64'(bvalid), 64'd0);

    // Table-driven transactions.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_read) begin
        axi_read(vecs[i].addr, d, r);
        check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
        check({vecs[i].name, "_resp"}, 64'(r), 64'(vecs[i].exp_resp));
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, p);
        check({vecs[i].name, "_resp"}, 64'(r), 64'(vecs[i].exp_resp));
        check({vecs[i].name, "_pulse"}, 64'(p), 64'(vecs[i].exp_wr));
      end
    end
    check("tbl_reg0", reg_q[0], 64'hFF);
    check("tbl_reg1", reg_q[1], 64'h0);
    check("tbl_reg2", reg_q[2], 64'h112233445566AA88);
    check("tbl_reg3", reg_q[3], 64'h1234);

    // AW without W: no acceptance; then back-pressure on B blocks a second write.
    @(negedge clk);
    awaddr = 32'h20; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("aw_only_awready", 64'(awready), 64'd0);
      check("aw_only_wready",  64'(wready),  64'd0);
      @(negedge clk);
    end
    wdata = 64'h44; wstrb = 8'hFF; wvalid = 1'b1;
    #1;
    check("aw_w_same_cycle", 64'(awready), 64'd1);
    @(negedge clk);
    awaddr = 32'h28; wdata = 64'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_bvalid_held",  64'(bvalid),  64'd1);
      check("bp_no_accept",    64'(awready), 64'd0);
      check("bp_reg5_intact",  reg_q[5],     64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    #1;
    check("bp_still_busy", 64'(awready), 64'd0);
    @(negedge clk);
    #1;
    check("bp_second_ready", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_reg4", reg_q[4], 64'h44);
    check("bp_reg5", reg_q[5], 64'h55);
    check("bp_bvalid2", 64'(bvalid), 64'd1);
    @(negedge clk);
    bready = 1'b0;

    // Same-cycle read and write to register 1: read returns the old value.
    axi_write(32'h08, 64'd5, 8'hFF, r, p);
    @(negedge clk);
    awaddr = 32'h08; wdata = 64'd9; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b1;
    #1;
    check("rw_both_ready", 64'({awready, arready}), 64'd3);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_old_value", rdata,    64'd5);
    check("rw_new_reg",   reg_q[1], 64'd9);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h08, d, r);
    check("rw_reread", d, 64'd9);

`ifdef SOC_CTRL_REGS_CYCLE_COUNTER_EN
    // Counter reads 10 accept-edges apart differ by 10; writes are refused.
    @(negedge clk);
    araddr = 32'h38; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    v1 = rdata;
    repeat (9) @(negedge clk);
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    v2 = rdata;
    @(negedge clk);
    rready = 1'b0;
    check("cnt_delta", v2 - v1, 64'd10);
    axi_write(32'h38, 64'h77, 8'hFF, r, p);
    check("cnt_wr_resp",  64'(r), 64'(SLVERR));
    check("cnt_wr_pulse", 64'(p), 64'd0);
`else
    // Top register is ordinary read/write storage.
    axi_write(32'h38, 64'h77, 8'hFF, r, p);
    check("reg7_wr_resp",  64'(r), 64'(OKAY));
    check("reg7_wr_pulse", 64'(p), 64'h80);
    axi_read(32'h38, d, r);
    check("reg7_rd", d, 64'h77);
    v1 = '0; v2 = '0;
`endif

    // Reset while both responses are pending.
    @(negedge clk);
    awaddr = 32'h10; wdata = 64'h5A; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    check("pre_rst_bvalid", 64'(bvalid), 64'd1);
    check("pre_rst_reg2",   reg_q[2],    64'h5A);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    check("mid_rst_reg2",   reg_q[2],    64'd0);
    check("mid_rst_reg0",   reg_q[0],    64'd0);
    check("mid_rst_reg7",   reg_q[7],    64'd0);
    check("mid_rst_rdata",  rdata,       64'd0);
    rst = 1'b0;
    axi_read(32'h10, d, r);
    check("post_rst_reg2", d, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_soc_ctrl_regs

// File: doc/soc_ctrl_regs.md
# soc_ctrl_regs

AXI4-Lite slave register file that sits behind the SoC interconnect and drives the `reg_q_o` control vector consumed by the system and the simulation bench. Writing `0xFF` to register 0 signals end of run. The block serialises one write and one read transaction independently, applies byte strobes, and returns OKAY/SLVERR responses. An optional read-only free-running cycle counter occupies the top register.

## Interface
Parameters:
- `AxiAddrWidth`, 32: AXI-Lite address width.
- `AxiDataWidth`, 64: data width and register width; power of two, at least 32.
- `NumRegs`, 8: number of registers; power of two, at least 2.

Ports:
- `clk` in, 1: single clock, all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `axil_awaddr_i` in, AxiAddrWidth; `axil_awvalid_i` in, 1; `axil_awready_o` out, 1.
- `axil_wdata_i` in, AxiDataWidth; `axil_wstrb_i` in, AxiDataWidth/8; `axil_wvalid_i` in, 1; `axil_wready_o` out, 1.
- `axil_bresp_o` out, 2; `axil_bvalid_o` out, 1; `axil_bready_i` in, 1.
- `axil_araddr_i` in, AxiAddrWidth; `axil_arvalid_i` in, 1; `axil_arready_o` out, 1.
- `axil_rdata_o` out, AxiDataWidth; `axil_rresp_o` out, 2; `axil_rvalid_o` out, 1; `axil_rready_i` in, 1.
- `reg_q_o` out, NumRegs x AxiDataWidth: current register contents.
- `reg_wr_o` out, NumRegs: one-cycle pulse per register, high in the cycle after it is written.

## Operation
- Decode: ByteOff = log2(AxiDataWidth/8); index = addr[ByteOff +: log2(NumRegs)].
  - Low ByteOff bits are ignored.
  - Any set bit above the index field is out of range and gives SLVERR (2'b10).
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, `awready` = `wready` = `awvalid && wvalid`. AW and W are accepted only together, never one channel alone.
  - On accept, bytes with strobe set are written. Go to W_RESP.
  - In W_RESP, `bvalid`=1 with the response latched at accept. Return to W_IDLE on `bready`.
  - No acceptance while in W_RESP.
- Read FSM, states R_IDLE and R_RESP:
  - In R_IDLE, `arready`=1.
  - On accept, latch rdata and rresp. Go to R_RESP.
  - In R_RESP, `rvalid`=1 and rdata is held stable. Return to R_IDLE on `rready`.
- Out-of-range write: no state change, no `reg_wr_o` pulse, SLVERR.
- Out-of-range read: rdata=0, SLVERR.
- Simultaneous read and write accept to the same register: the read returns the pre-write value.
- An all-zero `wstrb` is a legal write. It gives OKAY and a `reg_wr_o` pulse, with no data change.

## Timing
- Reset values:
  - All registers 0; `reg_wr_o`=0.
  - `bvalid`=`rvalid`=0; `bresp`=`rresp`=0; `rdata`=0.
  - `arready`=1 (R_IDLE); `awready`=`wready` follow their combinational rule from W_IDLE.
  - Cycle counter 0.
- Write accepted at edge T: `reg_q_o` and `reg_wr_o` update at T+1; `bvalid` is high from T+1.
- Read accepted at edge T: `rvalid` and `rdata` are valid from T+1.
- Minimum spacing is 2 cycles per transaction on each channel. `bready`/`rready` held high gives one transaction every 2 cycles.
- `bvalid`/`rvalid` stay high until their handshake completes, regardless of other activity.
- Reset asserted mid-transaction: both FSMs return to IDLE at the next edge, pending responses are dropped and all registers clear.

## Configuration
- `SOC_CTRL_REGS_CYCLE_COUNTER_EN` defined:
  - Register NumRegs-1 is a 64-bit free-running counter (truncated/zero-extended to AxiDataWidth). It increments every cycle while `rst` is low and wraps to 0.
  - Writes to it return SLVERR and change nothing; no `reg_wr_o` pulse.
  - `reg_q_o[NumRegs-1]` shows the counter.
- Undefined: register NumRegs-1 is an ordinary read/write register.

## Structure
- Shared package `soc_ctrl_pkg` holds:
  - the `axil_resp_t` values OKAY=2'b00 and SLVERR=2'b10;
  - the register index constants EXIT_REG=0 and CYCLE_REG=NumRegs-1;
  - the exit code 8'hFF.
- FSM state enums are local to the module.
- One sub-module: `soc_cycle_counter` (clk, rst, count_o), instantiated only under the macro.

## Test plan
- Reset, then write 0xFF to addr 0x0 with full strobe -> `reg_q_o[0]`=0xFF and `reg_wr_o[0]` pulse at T+1, `bvalid` at T+1, `bresp`=OKAY.
- Write 0x1122334455667788 to reg 2, then write 0xAA with wstrb=0x02 -> read of reg 2 returns 0x112233445566AA88, OKAY.
- Out-of-range accesses at addr 0x1000 -> write gives SLVERR with all registers unchanged; read gives rdata=0 with SLVERR.
- AW valid with W held low for 5 cycles -> `awready` stays 0; W raised -> accepted in the same cycle; `bready` low for 3 cycles -> `bvalid` held and a second write is not accepted.
- Same-cycle read and write to reg 1 (old value 5, new value 9) -> rdata=5; a subsequent read gives 9.
- With the macro: two reads 10 cycles apart at reg 7 -> the difference is 10; a write to reg 7 gives SLVERR. Assert `rst` mid-response -> `rvalid` low the next cycle and the counter returns to 0.
